pixel_swap_ctrl: RTL
====================

# pixel_swap_ctrl

Sequencer that drives the pixel DMA control slave of the VGA subsystem on behalf of the photo-manipulation engine. At start-up it reads the frame resolution; on each request it loads a new back-buffer base address, triggers a front/back swap, and polls the status register until the swap completes at the next vertical blank. It sits directly upstream of the VGA subsystem's pixel DMA control port, on the system clock domain.

## Interface
Parameters:
- POLL_GAP, 4, idle cycles between consecutive status reads (≥0)
- TIMEOUT_CYCLES, 2000000, poll abort limit in cycles (used only with SWAP_TIMEOUT_EN)

Ports:
- sys_clk_clk  in  1  system clock; all logic on rising edge
- sys_reset_reset  in  1  reset, asynchronous, active-high
- req_valid  in  1  swap request
- req_addr  in  32  new back-buffer base byte address
- req_ready  out  1  request accepted when req_valid && req_ready
- busy  out  1  high in every state except IDLE
- swap_done  out  1  one-cycle pulse: swap completed
- swap_timeout  out  1  one-cycle pulse: poll aborted (tied 0 without SWAP_TIMEOUT_EN)
- res_valid  out  1  resolution captured; held until reset
- res_width  out  16  pixels per line
- res_height  out  16  lines per frame
- ctl_address  out  2  control slave word address
- ctl_byteenable  out  4  4'hF while ctl_read or ctl_write, else 4'h0
- ctl_read  out  1  read strobe, one cycle
- ctl_write  out  1  write strobe, one cycle
- ctl_writedata  out  32  write data
- ctl_readdata  in  32  read data, valid exactly one cycle after ctl_read (no waitrequest)

## Operation
- Control register map: 0 Buffer (any write requests swap), 1 BackBuffer base, 2 Resolution (x in [15:0], y in [31:16]), 3 Status (bit 0 = swap pending).
- States: INIT_RD, INIT_WAIT, IDLE, WR_BACK, WR_SWAP, POLL_RD, POLL_WAIT, POLL_GAP_ST, DONE.
- INIT_RD: ctl_read=1, address 2. INIT_WAIT: capture width/height from ctl_readdata, set res_valid -> IDLE.
- IDLE: req_ready=1. On handshake latch req_addr with bits [1:0] forced to 0 -> WR_BACK.
- WR_BACK: ctl_write, address 1, writedata = latched address -> WR_SWAP.
- WR_SWAP: ctl_write, address 0, writedata 32'h0 -> POLL_RD.
- POLL_RD: ctl_read, address 3 -> POLL_WAIT.
- POLL_WAIT: readdata[0]=0 -> DONE; =1 -> POLL_GAP_ST (or POLL_RD directly if POLL_GAP=0).
- POLL_GAP_ST: count POLL_GAP cycles -> POLL_RD.
- DONE: swap_done=1 for one cycle -> IDLE.
- req_ready is 0 outside IDLE; requests during INIT or a swap are held off, never dropped or queued.
- Resolution is read once per reset only.

## Timing
- Reset values: all outputs 0 (ctl_address 2'd0, ctl_writedata 32'h0, res_width/res_height 16'h0, res_valid 0, req_ready 0, busy 0); state INIT_RD.
- Strobes and address/data are registered outputs, valid in the state named.
- First cycle after reset release: ctl_read at address 2; res_valid rises 2 cycles after release; req_ready rises the same cycle.
- Handshake at edge T: WR_BACK write at T+1, WR_SWAP write at T+2, first status read at T+3, sample at T+4; swap_done at T+5 if not pending.
- Each further poll adds 2+POLL_GAP cycles.
- Reset asserted mid-swap: immediate return to reset values; after release the sequence restarts from INIT_RD, including the resolution re-read.

## Configuration
- SWAP_TIMEOUT_EN defined: a 32-bit counter clears on entering WR_SWAP and increments every cycle in the poll states. When it reaches TIMEOUT_CYCLES in POLL_WAIT or POLL_GAP_ST, the block pulses swap_timeout instead of swap_done and returns to IDLE.
- SWAP_TIMEOUT_EN undefined: no counter; polling continues indefinitely; swap_timeout is constant 0.

## Test plan
- Reset release, ctl_readdata 32'h00F0_0140 on cycle 2 -> res_width 320, res_height 240, res_valid 1, req_ready 1 on that cycle.
- req_addr 32'h0800_0003, status reads 0 -> write 32'h0800_0000 to address 1, then write to address 0, one read of address 3, swap_done exactly at T+5.
- Status pending for 3 reads, POLL_GAP 4 -> 3 gaps of 4 cycles, swap_done at T+5+3×6 = T+23; req_ready low throughout.
- req_valid held high during INIT and during a swap -> accepted only in IDLE; exactly one swap per handshake.
- Reset asserted during POLL_WAIT -> all outputs 0 the same cycle; after release, INIT_RD re-reads address 2.
- With SWAP_TIMEOUT_EN, TIMEOUT_CYCLES 50, status stuck at 1 -> swap_timeout pulse, no swap_done, block returns to IDLE.

Source files
------------

// File: rtl/pixel_swap_ctrl.sv
// pixel_swap_ctrl: sequencer for the VGA pixel DMA control slave (resolution read, back-buffer load, swap, status poll).
//   clock/reset : sys_clk_clk, sys_reset_reset (async, active-high)
//   request     : req_valid, req_addr[31:0] -> req_ready, busy, swap_done, swap_timeout
//   resolution  : res_valid, res_width[15:0], res_height[15:0]
//   control bus : ctl_address[1:0], ctl_byteenable[3:0], ctl_read, ctl_write, ctl_writedata[31:0], ctl_readdata[31:0]
//   option      : define SWAP_TIMEOUT_EN to abort polling after TIMEOUT_CYCLES
module pixel_swap_ctrl #(
  parameter int unsigned POLL_GAP       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic        sys_clk_clk,
  input  logic        sys_reset_reset,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        busy,
  output logic        swap_done,
  output logic        swap_timeout,
  output logic        res_valid,
  output logic [15:0] res_width,
  output logic [15:0] res_height,
  output logic [1:0]  ctl_address,
  output logic [3:0]  ctl_byteenable,
  output logic        ctl_read,
  output logic        ctl_write,
  output logic [31:0] ctl_writedata,
  input  logic [31:0] ctl_readdata
);
  typedef enum logic [3:0] {
    INIT_RD, INIT_WAIT, IDLE, WR_BACK, WR_SWAP, POLL_RD, POLL_WAIT, POLL_GAP_ST, DONE
  } state_t;
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  state_t state, nx;
  logic run, gap_last, to_hit, unused_bits;
  logic [GW-1:0] gap_cnt;
  logic rd_d, wr_d, done_d, to_d;
  logic [1:0] addr_d;
  logic [31:0] wdata_d;
  // run holds INIT_RD for the first cycle after release so that its read strobe becomes visible
  always_ff @(posedge sys_clk_clk or posedge sys_reset_reset)
    if (sys_reset_reset) begin
      state   <= INIT_RD;
      run     <= 1'b0;
      gap_cnt <= '0;
    end else begin
      run     <= 1'b1;
      state   <= nx;
      gap_cnt <= (state == POLL_GAP_ST) ? gap_cnt + GW'(1) : '0;
    end
  assign gap_last = gap_cnt == GW'(POLL_GAP - 1);
`ifdef SWAP_TIMEOUT_EN
  logic [31:0] to_cnt;
  always_ff @(posedge sys_clk_clk or posedge sys_reset_reset)
    if (sys_reset_reset) to_cnt <= '0;
    else if (state == WR_BACK) to_cnt <= '0;
    else if (state == POLL_RD || state == POLL_WAIT || state == POLL_GAP_ST) to_cnt <= to_cnt + 32'd1;
  assign to_hit = to_cnt >= TIMEOUT_CYCLES;
  assign unused_bits = ^req_addr[1:0];
`else
  assign to_hit = 1'b0;
  assign unused_bits = ^{req_addr[1:0], TIMEOUT_CYCLES};
`endif
  always_comb begin
    nx = state;
    case (state)
      INIT_RD:     nx = run ? INIT_WAIT : INIT_RD;
      INIT_WAIT:   nx = IDLE;
      IDLE:        nx = req_valid ? WR_BACK : IDLE;
      WR_BACK:     nx = WR_SWAP;
      WR_SWAP:     nx = POLL_RD;
      POLL_RD:     nx = POLL_WAIT;
      POLL_WAIT:   nx = !ctl_readdata[0] ? DONE : to_hit ? IDLE : (POLL_GAP == 0) ? POLL_RD : POLL_GAP_ST;
      POLL_GAP_ST: nx = to_hit ? IDLE : gap_last ? POLL_RD : POLL_GAP_ST;
      DONE:        nx = IDLE;
      default:     nx = INIT_RD;
    endcase
  end
  // outputs are decoded from the next state and registered, so they are valid while in the named state
  always_comb begin
    rd_d    = nx == INIT_RD || nx == POLL_RD;
    wr_d    = nx == WR_BACK || nx == WR_SWAP;
    addr_d  = nx == INIT_RD ? 2'd2 : nx == WR_BACK ? 2'd1 : nx == POLL_RD ? 2'd3 : 2'd0;
    wdata_d = nx == WR_BACK ? {req_addr[31:2], 2'b00} : 32'h0;
    done_d  = nx == DONE;
    to_d    = to_hit && nx == IDLE && (state == POLL_WAIT || state == POLL_GAP_ST);
  end
  always_ff @(posedge sys_clk_clk or posedge sys_reset_reset)
    if (sys_reset_reset) begin
      ctl_read       <= 1'b0;
      ctl_write      <= 1'b0;
      ctl_address    <= 2'd0;
      ctl_byteenable <= 4'h0;
      ctl_writedata  <= 32'h0;
      swap_done      <= 1'b0;
      swap_timeout   <= 1'b0;
      busy           <= 1'b0;
      req_ready      <= 1'b0;
      res_valid      <= 1'b0;
      res_width      <= 16'h0;
      res_height     <= 16'h0;
    end else begin
      ctl_read       <= rd_d;
      ctl_write      <= wr_d;
      ctl_address    <= addr_d;
      ctl_byteenable <= (rd_d || wr_d) ? 4'hF : 4'h0;
      ctl_writedata  <= wdata_d;
      swap_done      <= done_d;
      swap_timeout   <= to_d;
      busy           <= nx != IDLE;
      req_ready      <= nx == IDLE;
      if (state == INIT_WAIT) begin
        res_valid  <= 1'b1;
        res_width  <= ctl_readdata[15:0];
        res_height <= ctl_readdata[31:16];
      end
    end
endmodule
